audio_nios_led_out: RTL and testbench

Avalon-MM output port for the audio Nios II system, driving the board LED bank; the write-side counterpart of the switch input port. Beyond plain data/set/clear registers it provides a hardware-timed one-shot pulse with a completion interrupt, so firmware can flash LEDs without polling. An optional hardware blink overlay is also available. Sits on the same Avalon slave fabric as the other PIOs.

---
 rtl/audio_nios_led_pkg.sv | 25 ++
 rtl/audio_nios_led_tick.sv | 34 +++
 rtl/audio_nios_led_out.sv | 232 +++++++++++++++++++++++
 tb/tb_audio_nios_led_out.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_nios_led_pkg.sv
// audio_nios_led_pkg
// Shared definitions for the audio Nios II LED output port:
//   - Avalon register word addresses (DATA .. BLINK_MASK; address 7 is reserved)
//   - STATUS register bit positions
//   - pulse FSM state encoding
package audio_nios_led_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_PULSE      = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN  = 3'd2;
  localparam logic [2:0] ADDR_STATUS     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET     = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd6;

  localparam int STATUS_BUSY_BIT   = 0;
  localparam int STATUS_DONE_BIT   = 1;
  localparam int STATUS_IRQ_EN_BIT = 2;

  typedef enum logic [0:0] {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/audio_nios_led_tick.sv
// audio_nios_led_tick
// Free-running prescaler. It counts 0..TICK_DIV-1 and asserts tick for one
// clk cycle while the count sits at its terminal value.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   tick     one-cycle strobe, once every TICK_DIV cycles
module audio_nios_led_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == TERM);

  // Prescaler counter: wraps to zero at the terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/audio_nios_led_out.sv
// audio_nios_led_out
// Avalon-MM LED output port. It provides DATA/OUTSET/OUTCLEAR registers, a
// tick-timed one-shot pulse with a sticky done flag and interrupt, and an
// optional blink overlay that is compiled in when AUDIO_NIOS_LED_BLINK_EN is
// defined.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address/chipselect/   Avalon slave write side; write = chipselect & ~write_n
//   write_n/writedata
//   readdata              registered read data; follows address every cycle
//   irq                   done & irq_en (registered)
//   out_port              registered LED drive
module audio_nios_led_out
  import audio_nios_led_pkg::*;
#(
  parameter int WIDTH       = 18,
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  logic             tick_s;
  logic             wr_s;
  logic [WIDTH-1:0] wmask_s;
  logic             unused_wd_s;

  pulse_state_e     state_r, state_nxt_s;
  logic [WIDTH-1:0] data_r, data_nxt_s;
  logic [WIDTH-1:0] active_r, active_nxt_s;
  logic [15:0]      timer_r, timer_nxt_s;
  logic [15:0]      len_r, len_nxt_s;
  logic             irq_en_r, irq_en_nxt_s;
  logic             done_r, done_nxt_s;
  logic             done_set_s, done_clr_s;
  logic [WIDTH-1:0] out_nxt_s;
  logic [31:0]      rd_s;
  logic [31:0]      readdata_r;
  logic             irq_r;
  logic [WIDTH-1:0] out_port_r;

  audio_nios_led_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_s)
  );

  assign wr_s        = chipselect & ~write_n;
  assign wmask_s     = writedata[WIDTH-1:0];
  assign unused_wd_s = ^writedata;

  // Pulse FSM plus CPU register writes; CPU data writes land after a pulse
  // clear so software always has the last word in a collision.
  always_comb begin
    state_nxt_s  = state_r;
    data_nxt_s   = data_r;
    active_nxt_s = active_r;
    timer_nxt_s  = timer_r;
    len_nxt_s    = len_r;
    irq_en_nxt_s = irq_en_r;
    done_set_s   = 1'b0;
    done_clr_s   = 1'b0;

    case (state_r)
      PULSE_IDLE: begin
        if (wr_s && (address == ADDR_PULSE) && (wmask_s != '0)) begin
          state_nxt_s  = PULSE_ACTIVE;
          active_nxt_s = wmask_s;
          timer_nxt_s  = len_r;
          data_nxt_s   = data_r | wmask_s;
        end else begin
          state_nxt_s  = PULSE_IDLE;
        end
      end
      PULSE_ACTIVE: begin
        if (wr_s && (address == ADDR_PULSE) && (wmask_s != '0)) begin
          // Retrigger: widen the mask and restart the full length.
          active_nxt_s = active_r | wmask_s;
          data_nxt_s   = data_r | wmask_s;
          timer_nxt_s  = len_r;
        end else if (tick_s) begin
          if (timer_r == 16'd0) begin
            data_nxt_s   = data_r & ~active_r;
            active_nxt_s = '0;
            done_set_s   = 1'b1;
            state_nxt_s  = PULSE_IDLE;
          end else begin
            timer_nxt_s  = timer_r - 16'd1;
          end
        end else begin
          state_nxt_s  = PULSE_ACTIVE;
        end
      end
      default: begin
        state_nxt_s  = PULSE_IDLE;
        active_nxt_s = '0;
      end
    endcase

    if (wr_s) begin
      case (address)
        ADDR_DATA:      data_nxt_s   = wmask_s;
        ADDR_OUTSET:    data_nxt_s   = data_nxt_s | wmask_s;
        ADDR_OUTCLEAR:  data_nxt_s   = data_nxt_s & ~wmask_s;
        ADDR_PULSE_LEN: len_nxt_s    = writedata[15:0];
        ADDR_STATUS: begin
          irq_en_nxt_s = writedata[STATUS_IRQ_EN_BIT];
          done_clr_s   = writedata[STATUS_BUSY_BIT];
        end
        default: begin
        end
      endcase
    end else begin
      len_nxt_s = len_r;
    end

    // A pulse completing in the same cycle as a clear request must not be lost.
    if (done_set_s) begin
      done_nxt_s = 1'b1;
    end else if (done_clr_s) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
  end

`ifdef AUDIO_NIOS_LED_BLINK_EN
  localparam int BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BCW-1:0] BTERM = BCW'(BLINK_TICKS - 1);

  logic [WIDTH-1:0] blink_mask_r, blink_mask_nxt_s;
  logic [BCW-1:0]   bcnt_r, bcnt_nxt_s;
  logic             phase_r, phase_nxt_s;

  // Blink phase counter and mask register next-state.
  always_comb begin
    blink_mask_nxt_s = blink_mask_r;
    bcnt_nxt_s       = bcnt_r;
    phase_nxt_s      = phase_r;
    if (wr_s && (address == ADDR_BLINK_MASK)) begin
      blink_mask_nxt_s = wmask_s;
    end else begin
      blink_mask_nxt_s = blink_mask_r;
    end
    if (tick_s) begin
      if (bcnt_r == BTERM) begin
        bcnt_nxt_s  = '0;
        phase_nxt_s = ~phase_r;
      end else begin
        bcnt_nxt_s  = bcnt_r + BCW'(1);
      end
    end else begin
      bcnt_nxt_s = bcnt_r;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask_r <= '0;
      bcnt_r       <= '0;
      phase_r      <= 1'b0;
    end else begin
      blink_mask_r <= blink_mask_nxt_s;
      bcnt_r       <= bcnt_nxt_s;
      phase_r      <= phase_nxt_s;
    end
  end

  assign out_nxt_s = data_nxt_s ^ (blink_mask_nxt_s & {WIDTH{phase_nxt_s}});
`else
  logic unused_blink_s;
  assign unused_blink_s = (BLINK_TICKS > 0);
  assign out_nxt_s      = data_nxt_s;
`endif

  // Read mux over the current register contents; not gated by chipselect.
  always_comb begin
    rd_s = 32'd0;
    case (address)
      ADDR_DATA:       rd_s = 32'(data_r);
      ADDR_PULSE:      rd_s = 32'(active_r);
      ADDR_PULSE_LEN:  rd_s = {16'd0, len_r};
      ADDR_STATUS:     rd_s = {29'd0, irq_en_r, done_r, (state_r == PULSE_ACTIVE)};
`ifdef AUDIO_NIOS_LED_BLINK_EN
      ADDR_BLINK_MASK: rd_s = 32'(blink_mask_r);
`endif
      default:         rd_s = 32'd0;
    endcase
  end

  // Core state and output registers; outputs load from next-state so a write
  // is visible on out_port the cycle after it is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= PULSE_IDLE;
      data_r     <= '0;
      active_r   <= '0;
      timer_r    <= 16'd0;
      len_r      <= 16'd0;
      irq_en_r   <= 1'b0;
      done_r     <= 1'b0;
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
      out_port_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      data_r     <= data_nxt_s;
      active_r   <= active_nxt_s;
      timer_r    <= timer_nxt_s;
      len_r      <= len_nxt_s;
      irq_en_r   <= irq_en_nxt_s;
      done_r     <= done_nxt_s;
      readdata_r <= rd_s;
      irq_r      <= done_nxt_s & irq_en_nxt_s;
      out_port_r <= out_nxt_s;
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;
  assign out_port = out_port_r;

endmodule

// File: tb/tb_audio_nios_led_out.sv
module tb_audio_nios_led_out;

  localparam int W  = 18;
  localparam int TD = 4;
  localparam int BT = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic          irq;
  logic [W-1:0]  out_port;

  int total = 0;
  int bad   = 0;

  // Reference model state (abstract: cycle count since reset, pulse as a mask
  // plus remaining-ticks counter, blink phase derived from elapsed ticks).
  logic [W-1:0]  m_data, m_active, m_bmask;
  logic [15:0]   m_len;
  int            m_left;
  bit            m_busy, m_done, m_irq_en;
  longint        m_n;
  logic [31:0]   m_rd;
  logic [W-1:0]  m_out;
  bit            m_irq;

  audio_nios_led_out #(.WIDTH(W), .TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_data = '0; m_active = '0; m_bmask = '0; m_len = 16'd0; m_left = 0;
    m_busy = 1'b0; m_done = 1'b0; m_irq_en = 1'b0; m_n = 0;
    m_rd = 32'd0; m_out = '0; m_irq = 1'b0;
  endtask

  function automatic bit m_tick_now();
    return (m_n % TD) == (TD - 1);
  endfunction

  function automatic bit m_pulse_ends_now();
    return m_busy && m_tick_now() && (m_left == 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_data);
      3'd1: return 32'(m_active);
      3'd2: return {16'd0, m_len};
      3'd3: return {29'd0, m_irq_en, m_done, m_busy};
`ifdef AUDIO_NIOS_LED_BLINK_EN
      3'd6: return 32'(m_bmask);
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle of the model with the bus inputs that were presented.
  task automatic model_cycle(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] wd);
    logic [W-1:0] mask;
    bit wr, ended;
    bit phase;
    mask  = wd[W-1:0];
    wr    = cs && !wn;
    ended = 1'b0;
    m_rd  = m_read(a);
    if (wr && a == 3'd1 && mask != '0) begin
      m_active = m_busy ? (m_active | mask) : mask;
      m_data   = m_data | mask;
      m_left   = int'(m_len);
      m_busy   = 1'b1;
    end else if (m_busy && m_tick_now()) begin
      if (m_left == 0) begin
        m_data   = m_data & ~m_active;
        m_active = '0;
        m_busy   = 1'b0;
        ended    = 1'b1;
      end else begin
        m_left = m_left - 1;
      end
    end
    if (wr) begin
      case (a)
        3'd0: m_data = mask;
        3'd2: m_len  = wd[15:0];
        3'd3: begin
          m_irq_en = wd[2];
          if (wd[0] && !ended) m_done = 1'b0;
        end
        3'd4: m_data = m_data | mask;
        3'd5: m_data = m_data & ~mask;
`ifdef AUDIO_NIOS_LED_BLINK_EN
        3'd6: m_bmask = mask;
`endif
        default: ;
      endcase
    end
    if (ended) m_done = 1'b1;
    m_n = m_n + 1;
`ifdef AUDIO_NIOS_LED_BLINK_EN
    phase = ((m_n / TD) / BT) % 2 == 1;
`else
    phase = 1'b0;
`endif
    m_out = m_data ^ (phase ? m_bmask : '0);
    m_irq = m_done && m_irq_en;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] wd);
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    model_cycle(cs, wn, a, wd);
    #1;
    chk("out_port", 32'(out_port), 32'(m_out));
    chk("readdata", readdata, m_rd);
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    step(1'b1, 1'b0, a, wd);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 3'd0, 32'd0);
  endtask

  initial begin
    int hi;
    bit hit;
    logic [31:0] exp6;

    // Reset: outputs must be zero while reset is held and after release.
    model_reset();
    #12;
    chk("reset_out", 32'(out_port), 32'd0);
    chk("reset_rd", readdata, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      step(1'b0, 1'b1, 3'(a), 32'd0);
      chk("reset_read_all", readdata, 32'd0);
    end

    // DATA / OUTSET / OUTCLEAR.
    wr(3'd0, 32'h0000_00F0);
    wr(3'd4, 32'h0000_0003);
    wr(3'd5, 32'h0000_0010);
    chk("set_clear_out", 32'(out_port), 32'h0000_00E3);
    step(1'b0, 1'b1, 3'd0, 32'd0);
    chk("set_clear_read", readdata, 32'h0000_00E3);
    step(1'b0, 1'b1, 3'd4, 32'd0);
    chk("outset_reads0", readdata, 32'd0);

    // One-shot pulse with interrupt.
    wr(3'd2, 32'd3);
    wr(3'd3, 32'h4);
    wr(3'd1, 32'h100);
    hi = 0;
    while (out_port[8] && hi < 40) begin
      hi++;
      idle();
    end
    chk("pulse_len_range", 32'((hi >= 13) && (hi <= 16)), 32'd1);
    step(1'b0, 1'b1, 3'd3, 32'd0);
    chk("status_done", readdata, 32'h6);
    chk("irq_set", 32'(irq), 32'd1);
    wr(3'd3, 32'h1);
    chk("irq_cleared", 32'(irq), 32'd0);

    // Retrigger: bits 0 and 1 must drop together, counted from the second write.
    wr(3'd0, 32'd0);
    wr(3'd1, 32'h1);
    for (int i = 0; i < 2 * TD; i++) idle();
    wr(3'd1, 32'h2);
    hi = 1;
    while (out_port[1:0] != 2'b00 && hi < 40) begin
      chk("retrig_both_on", 32'(out_port[1:0]), 32'h3);
      hi++;
      idle();
    end
    chk("retrig_len_range", 32'((hi >= 13) && (hi <= 16)), 32'd1);
    step(1'b0, 1'b1, 3'd3, 32'd0);
    chk("retrig_done", readdata, 32'h2);

    // CPU write in the pulse-end cycle wins.
    wr(3'd2, 32'd0);
    wr(3'd1, 32'h1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_pulse_ends_now()) begin
        wr(3'd0, 32'h1);
        hit = 1'b1;
      end else begin
        idle();
      end
    end
    chk("cpu_wins_seen", 32'(hit), 32'd1);
    chk("cpu_wins_out", 32'(out_port), 32'h1);

    // Blink overlay (or its absence).
    wr(3'd0, 32'd0);
    wr(3'd6, 32'h1);
    step(1'b0, 1'b1, 3'd6, 32'd0);
`ifdef AUDIO_NIOS_LED_BLINK_EN
    exp6 = 32'h1;
`else
    exp6 = 32'h0;
`endif
    chk("blink_mask_read", readdata, exp6);
    for (int i = 0; i < 4 * TD * BT; i++) idle();

    // Reset in the middle of a pulse.
    wr(3'd2, 32'd5);
    wr(3'd1, 32'hF);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midreset_out", 32'(out_port), 32'd0);
    chk("midreset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 3'd3, 32'd0);
    chk("midreset_status", readdata, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd2) wd = 32'($urandom_range(0, 3));
      if (a == 3'd1 && $urandom_range(0, 3) == 0) wd = 32'd0;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
